// File: rtl/aes_pkg.sv
// aes_pkg
//   Shared AES-128 key-schedule constants, the key-schedule FSM state type,
//   the forward S-box table and the GF(2^8) xtime helper used to advance Rcon.
package aes_pkg;

  localparam int unsigned AES_NK    = 4;      // key length in 32-bit words
  localparam int unsigned AES_NR    = 10;     // rounds for AES-128
  localparam logic [7:0]  RCON_INIT = 8'h01;
  localparam logic [7:0]  RCON_POLY = 8'h1b;  // x^8 reduction term

  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_EXPAND = 2'd1,
    KS_DONE   = 2'd2
  } ks_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8): shift left, reduce on carry out of bit 7.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/key_round_step.sv
// key_round_step
//   Combinational AES-128 round-key step: derives round key r from round
//   key r-1 using RotWord, SubWord (four S-boxes) and the Rcon XOR.
// Ports
//   prev_rk  in  128  previous round key, word0 = [127:96]
//   rcon     in  8    round constant for this step
//   next_rk  out 128  next round key
module key_round_step
  import aes_pkg::*;
(
  input  logic [127:0] prev_rk,
  input  logic [7:0]   rcon,
  output logic [127:0] next_rk
);

  logic [31:0] rot_w;
  logic [31:0] sub_w;
  logic [31:0] t_w;
  logic [31:0] w0, w1, w2, w3;

  always_comb begin
    rot_w = {prev_rk[23:0], prev_rk[31:24]};
    sub_w = {aes_sbox(rot_w[31:24]), aes_sbox(rot_w[23:16]),
             aes_sbox(rot_w[15:8]),  aes_sbox(rot_w[7:0])};
    t_w   = sub_w ^ {rcon, 24'h000000};
    w0    = prev_rk[127:96] ^ t_w;
    w1    = w0 ^ prev_rk[95:64];
    w2    = w1 ^ prev_rk[63:32];
    w3    = w2 ^ prev_rk[31:0];
    next_rk = {w0, w1, w2, w3};
  end

endmodule

// File: rtl/key_schedule_seq.sv
// key_schedule_seq
//   Iterative AES-128 key-schedule sequencer. Accepts a cipher key over
//   valid/ready, produces one round key per clock through a single shared
//   key_round_step, stores all 11 round keys and serves them on a registered
//   read port with one cycle of latency.
// Ports
//   clk         in   1    clock, rising edge
//   rst_n       in   1    asynchronous active-low reset
//   key_in      in   128  cipher key, word0 = [127:96]
//   key_valid   in   1    key_in valid
//   key_ready   out  1    key can be accepted (IDLE or DONE)
//   clear       in   1    synchronous return to IDLE; store contents kept
//   busy        out  1    expansion in progress
//   keys_valid  out  1    all round keys stored
//   rk_rd_en    in   1    read strobe
//   rk_rd_idx   in   4    round-key index 0..10
//   rk_rd_data  out  128  round key (0 for index > 10)
//   rk_rd_vld   out  1    rk_rd_en delayed by one cycle
module key_schedule_seq
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES_NR,  // only 10 is supported
  parameter int unsigned KEY_W      = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic             clear,
  output logic             busy,
  output logic             keys_valid,
  input  logic             rk_rd_en,
  input  logic [3:0]       rk_rd_idx,
  output logic [KEY_W-1:0] rk_rd_data,
  output logic             rk_rd_vld
);

  localparam int unsigned NUM_SLOTS = NUM_ROUNDS + 1;
  localparam logic [3:0]  LAST_IDX  = 4'(NUM_ROUNDS);

  ks_state_e        state_q;
  logic             key_ready_q;
  logic             busy_q;
  logic             keys_valid_q;
  logic [3:0]       round_q;
  logic [7:0]       rcon_q;
  logic [KEY_W-1:0] work_q;
  logic [KEY_W-1:0] store_q [NUM_SLOTS];
  logic [KEY_W-1:0] rd_data_q;
  logic             rd_vld_q;

  logic [KEY_W-1:0] step_rk;
  logic             accept;
  logic             wr_en_d;
  logic [3:0]       wr_idx_d;
  logic [KEY_W-1:0] wr_data_d;

  key_round_step u_step (
    .prev_rk (work_q),
    .rcon    (rcon_q),
    .next_rk (step_rk)
  );

  // key_ready_q is high exactly in IDLE/DONE; clear blocks a same-cycle accept.
  assign accept = key_valid && key_ready_q && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= KS_IDLE;
      key_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      round_q      <= '0;
      rcon_q       <= RCON_INIT;
      work_q       <= '0;
    end else if (clear) begin
      state_q      <= KS_IDLE;
      key_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      keys_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        KS_IDLE, KS_DONE: begin
          if (accept) begin
            work_q       <= key_in;
            round_q      <= 4'd1;
            rcon_q       <= RCON_INIT;
            keys_valid_q <= 1'b0;
            busy_q       <= 1'b1;
            key_ready_q  <= 1'b0;
            state_q      <= KS_EXPAND;
          end
        end
        KS_EXPAND: begin
          work_q  <= step_rk;
          rcon_q  <= xtime(rcon_q);
          round_q <= round_q + 4'd1;
          if (round_q == LAST_IDX) begin
            keys_valid_q <= 1'b1;
            busy_q       <= 1'b0;
            key_ready_q  <= 1'b1;
            state_q      <= KS_DONE;
          end
        end
        default: begin
          state_q     <= KS_IDLE;
          key_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Slot 0 gets the raw key on accept; slot r gets round key r while expanding.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_idx_d  = '0;
    wr_data_d = '0;
    if (accept) begin
      wr_en_d   = 1'b1;
      wr_idx_d  = '0;
      wr_data_d = key_in;
    end else if (!clear && state_q == KS_EXPAND) begin
      wr_en_d   = 1'b1;
      wr_idx_d  = round_q;
      wr_data_d = step_rk;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        store_q[i] <= '0;
      end
    end else if (wr_en_d) begin
      store_q[wr_idx_d] <= wr_data_d;
    end
  end

  // Read samples the store before this edge's write lands, so a same-slot
  // read/write returns the previous contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      rd_vld_q <= rk_rd_en;
      if (rk_rd_en) begin
        rd_data_q <= (rk_rd_idx <= LAST_IDX) ? store_q[rk_rd_idx] : '0;
      end
    end
  end

  assign key_ready  = key_ready_q;
  assign busy       = busy_q;
  assign keys_valid = keys_valid_q;
  assign rk_rd_data = rd_data_q;
  assign rk_rd_vld  = rd_vld_q;

endmodule

// File: tb/tb_key_schedule_seq.sv
module tb_key_schedule_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         clear;
  logic         busy;
  logic         keys_valid;
  logic         rk_rd_en;
  logic [3:0]   rk_rd_idx;
  logic [127:0] rk_rd_data;
  logic         rk_rd_vld;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

  logic [7:0]   sb [256];
  logic [127:0] model_rk [11];

  key_schedule_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .clear      (clear),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rk_rd_en   (rk_rd_en),
    .rk_rd_idx  (rk_rd_idx),
    .rk_rd_data (rk_rd_data),
    .rk_rd_vld  (rk_rd_vld)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse, then affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++)
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Textbook word-array key expansion (w[0..43]).
  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    int rc = 1;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc[7:0], 24'h0};
        rc = rc * 2;
        if (rc > 255) rc = rc ^ 'h11b;
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; the following rising edge is the accept edge.
  task automatic start_key(input logic [127:0] k);
    key_in = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Called at the negedge after the accept edge; counts cycles to keys_valid.
  task automatic wait_done(input string name, input int start_cnt);
    int c = start_cnt;
    while (!keys_valid && c < 25) begin
      @(negedge clk);
      c++;
    end
    check(name, 128'(c), 128'd10);
  endtask

  task automatic read_slot(input logic [3:0] idx, output logic [127:0] d);
    rk_rd_en = 1'b1;
    rk_rd_idx = idx;
    @(negedge clk);
    rk_rd_en = 1'b0;
    d = rk_rd_data;
    check("rd_vld", 128'(rk_rd_vld), 128'd1);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [3:0]   idx;
    logic [127:0] exp;
  } vec_t;

  initial begin
    vec_t         tbl [7];
    logic [127:0] d;
    logic [127:0] cur;
    logic [127:0] k;
    logic [127:0] rkeys [4];
    int           c;

    for (int i = 0; i < 256; i++) sb[i] = sbox_ref(8'(i));

    key_in = '0; key_valid = 1'b0; clear = 1'b0; rk_rd_en = 1'b0; rk_rd_idx = '0;

    tbl[0] = '{FIPS_KEY, 4'd0,  FIPS_KEY};
    tbl[1] = '{FIPS_KEY, 4'd1,  FIPS_RK1};
    tbl[2] = '{FIPS_KEY, 4'd10, FIPS_RK10};
    tbl[3] = '{FIPS_KEY, 4'd15, 128'h0};
    tbl[4] = '{128'h0,   4'd10, ZERO_RK10};
    tbl[5] = '{128'h0,   4'd0,  128'h0};
    tbl[6] = '{128'h0,   4'd11, 128'h0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_key_ready",  128'(key_ready),  128'd1);
    check("rst_busy",       128'(busy),       128'd0);
    check("rst_keys_valid", 128'(keys_valid), 128'd0);
    check("rst_rd_vld",     128'(rk_rd_vld),  128'd0);
    check("rst_rd_data",    rk_rd_data,       128'h0);
    rst_n = 1'b1;
    @(negedge clk);
    read_slot(4'd5, d);
    check("rst_store", d, 128'h0);

    // Known-answer table
    cur = '1;
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].key !== cur) begin
        start_key(tbl[i].key);
        wait_done("kat_latency", 0);
        cur = tbl[i].key;
      end
      read_slot(tbl[i].idx, d);
      check($sformatf("kat_%0d_idx%0d", i, tbl[i].idx), d, tbl[i].exp);
    end

    // key_valid held through EXPAND with a different key
    key_in = FIPS_KEY;
    key_valid = 1'b1;
    @(negedge clk);
    key_in = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    c = 0;
    while (!keys_valid && c < 25) begin
      check("hold_key_ready", 128'(key_ready), 128'd0);
      check("hold_busy",      128'(busy),      128'd1);
      @(negedge clk);
      c++;
    end
    key_valid = 1'b0;
    check("hold_latency", 128'(c), 128'd10);
    check("done_busy",      128'(busy),      128'd0);
    check("done_key_ready", 128'(key_ready), 128'd1);
    repeat (2) @(negedge clk);
    check("done_stays", 128'(keys_valid), 128'd1);
    model_expand(FIPS_KEY);
    for (int r = 0; r < 11; r++) begin
      read_slot(4'(r), d);
      check($sformatf("hold_rk%0d", r), d, model_rk[r]);
    end

    // Same-slot read/write returns old contents (slot0 at accept, slot1 at E1)
    key_in = '0;
    key_valid = 1'b1;
    rk_rd_en = 1'b1;
    rk_rd_idx = 4'd0;
    @(negedge clk);
    key_valid = 1'b0;
    check("coll_slot0", rk_rd_data, FIPS_KEY);
    check("coll_drop_valid", 128'(keys_valid), 128'd0);
    rk_rd_idx = 4'd1;
    @(negedge clk);
    rk_rd_en = 1'b0;
    check("coll_slot1", rk_rd_data, FIPS_RK1);
    wait_done("coll_latency", 1);

    // Back-to-back reads 0..10 then 15 (zero key stored; covers Rcon 80->1b->36)
    model_expand(128'h0);
    for (int i = 0; i < 12; i++) begin
      rk_rd_en = 1'b1;
      rk_rd_idx = (i == 11) ? 4'd15 : 4'(i);
      @(negedge clk);
      check($sformatf("b2b_vld_%0d", i), 128'(rk_rd_vld), 128'd1);
      check($sformatf("b2b_data_%0d", i), rk_rd_data, (i == 11) ? 128'h0 : model_rk[i]);
    end
    rk_rd_en = 1'b0;
    @(negedge clk);
    check("b2b_vld_off", 128'(rk_rd_vld), 128'd0);

    // Random keys against the reference model
    for (int n = 0; n < 4; n++) rkeys[n] = {$urandom, $urandom, $urandom, $urandom};
    for (int n = 0; n < 4; n++) begin
      start_key(rkeys[n]);
      wait_done("rand_latency", 0);
      model_expand(rkeys[n]);
      for (int r = 0; r < 11; r++) begin
        read_slot(4'(r), d);
        check($sformatf("rand%0d_rk%0d", n, r), d, model_rk[r]);
      end
    end

    // Reset asserted before E5 aborts; reload FIPS key
    start_key(rkeys[0] ^ 128'h1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_key_ready",  128'(key_ready),  128'd1);
    check("abort_busy",       128'(busy),       128'd0);
    check("abort_keys_valid", 128'(keys_valid), 128'd0);
    check("abort_rd_vld",     128'(rk_rd_vld),  128'd0);
    check("abort_rd_data",    rk_rd_data,       128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_slot(4'd10, d);
    check("abort_store", d, 128'h0);
    check("abort_kv_low", 128'(keys_valid), 128'd0);
    start_key(FIPS_KEY);
    wait_done("reload_latency", 0);
    read_slot(4'd10, d);
    check("reload_rk10", d, FIPS_RK10);

    // clear and key_valid together in DONE: clear wins, store kept
    key_in = 128'h0badf00d_0badf00d_0badf00d_0badf00d;
    key_valid = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    clear = 1'b0;
    check("clr_keys_valid", 128'(keys_valid), 128'd0);
    check("clr_key_ready",  128'(key_ready),  128'd1);
    check("clr_busy",       128'(busy),       128'd0);
    repeat (3) begin
      @(negedge clk);
      check("clr_no_expand", 128'(busy), 128'd0);
    end
    check("clr_kv_still_low", 128'(keys_valid), 128'd0);
    read_slot(4'd0, d);
    check("clr_slot0", d, FIPS_KEY);
    read_slot(4'd10, d);
    check("clr_slot10", d, FIPS_RK10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
